muldiv_unit: RTL

- Iterative RV64M multiply/divide execute unit.
- Consumes the two source operands read from the general-purpose register file and returns a destination tag plus a 64-bit result to the writeback path that drives the register-file write port.
- Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W variants. Uses one shift-add or restoring-divide step per cycle behind a valid/ready handshake.

---
 rtl/muldiv_unit_if.sv | 46 ++++
 rtl/muldiv_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// muldiv_unit_if
//
// Request/response bundle between the issue stage, the muldiv_unit and the
// writeback path.
//
//   Request  (master -> slave): valid_i, op_i, word_i, rs1_data_i, rs2_data_i,
//                               rd_i, kill_i
//   Handshake(slave -> master): ready_o, busy_o
//   Response (slave -> master): valid_o, rd_o, rd_data_o
//   Response accept (master -> slave): ready_i
//
// The signal names keep the unit-relative _i/_o suffixes so that they line up
// with the unit's documented port list.
// -----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic            word_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [4:0]      rd_i;
    logic            kill_i;
    logic            valid_o;
    logic            ready_i;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] rd_data_o;
    logic            busy_o;

    // Issue/writeback side.
    modport master (
        output valid_i, op_i, word_i, rs1_data_i, rs2_data_i, rd_i, kill_i,
        output ready_i,
        input  ready_o, busy_o, valid_o, rd_o, rd_data_o
    );

    // Execute unit side.
    modport slave (
        input  valid_i, op_i, word_i, rs1_data_i, rs2_data_i, rd_i, kill_i,
        input  ready_i,
        output ready_o, busy_o, valid_o, rd_o, rd_data_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV64M multiply/divide execute unit. One shift-add (multiply) or
// restoring-divide step per cycle on operand magnitudes, followed by a single
// sign-fix / result-select cycle.
//
// Ports:
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : muldiv_unit_if.slave
//              valid_i/ready_o     request handshake (ready_o = idle)
//              op_i                RISC-V M funct3
//              word_i              W variant (MUL and divide ops only)
//              rs1_data_i/rs2_data_i operands
//              rd_i                destination register index
//              kill_i              pipeline flush
//              valid_o/ready_i     result handshake
//              rd_o/rd_data_o      captured destination and result
//              busy_o              unit not idle
//
// Latency: N+1 cycles from acceptance to valid_o (N = 64, or 32 for W ops);
// divide-by-zero and signed overflow take 1 cycle.
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    muldiv_unit_if.slave bus
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    state_e state_q, state_d;

    // Captured request and iteration state.
    logic [2:0]        op_q;
    logic              word_q;
    logic [4:0]        rd_q;
    logic [5:0]        count_q;
    logic              neg_res_q;   // negate product / quotient in FIX
    logic              neg_rem_q;   // negate remainder in FIX
    logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   acc_hi_q;    // product high half / partial remainder
    logic [XLEN-1:0]   acc_lo_q;    // product low half + multiplier / dividend-quotient
    logic [4:0]        rd_out_q;
    logic [XLEN-1:0]   rd_data_q;

    logic accept;
    logic last_iter;

    assign accept    = (state_q == IDLE) && bus.valid_i && !bus.kill_i;
    assign last_iter = (count_q == (word_q ? 6'd31 : 6'd63));

    // -------------------------------------------------------------------------
    // Request decode: operand extension, magnitudes and special divide cases.
    // -------------------------------------------------------------------------
    logic            is_div;
    logic            eff_word;
    logic            a_signed;
    logic            b_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] min_val;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        is_div   = bus.op_i[2];
        // W has no meaning for MULH*; those run as the 64-bit operation.
        eff_word = bus.word_i && (is_div || (bus.op_i == OP_MUL));
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.op_i)
            OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default:   ;
        endcase

        // MUL keeps both operands unsigned: the low product bits are the
        // same whether or not the operands are treated as signed.
        if (eff_word) begin
            a_ext   = {{32{a_signed & bus.rs1_data_i[31]}}, bus.rs1_data_i[31:0]};
            b_ext   = {{32{b_signed & bus.rs2_data_i[31]}}, bus.rs2_data_i[31:0]};
            min_val = {{33{1'b1}}, 31'b0};
        end else begin
            a_ext   = bus.rs1_data_i;
            b_ext   = bus.rs2_data_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end

        a_neg    = a_signed & a_ext[XLEN-1];
        b_neg    = b_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && a_signed && (a_ext == min_val) && (b_ext == '1);
    end

    // -------------------------------------------------------------------------
    // One iteration step.
    // -------------------------------------------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the 128-bit {carry, hi, lo} right by one.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor when it fits.
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // Only used when div_ge, so the result always fits in XLEN bits.
        div_diff  = div_shift[XLEN-1:0] - opnd_q;
    end

    // -------------------------------------------------------------------------
    // Sign correction and result select (used in FIX).
    // -------------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
        raw      = '0;
        case (op_q)
            // A 32-iteration multiply leaves its 64-bit product at [95:32].
            OP_MUL:                      raw = word_q ? prod_fix[95:32] : prod_fix[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: raw = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             raw = quot_fix;
            OP_REM, OP_REMU:             raw = rem_fix;
            default:                     raw = '0;
        endcase
        result = word_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the edge.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (div_zero || div_ovf) ? FIX : CALC;
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = bus.kill_i ? IDLE : DONE;
            DONE: begin
                if (bus.kill_i || bus.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q      <= '0;
            word_q    <= 1'b0;
            rd_q      <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            rd_out_q  <= '0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.op_i;
                        word_q    <= eff_word;
                        rd_q      <= bus.rd_i;
                        count_q   <= '0;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        if (div_zero) begin
                            // Final quotient/remainder loaded directly; no
                            // sign correction is applied to them.
                            neg_res_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            acc_lo_q  <= '1;
                            acc_hi_q  <= a_ext;
                            opnd_q    <= '0;
                        end else if (div_ovf) begin
                            neg_res_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            acc_lo_q  <= a_ext;
                            acc_hi_q  <= '0;
                            opnd_q    <= '0;
                        end else if (is_div) begin
                            // A W dividend sits in the top half so its bits
                            // are shifted out first.
                            opnd_q   <= b_mag;
                            acc_hi_q <= '0;
                            acc_lo_q <= eff_word ? {a_mag[31:0], 32'b0} : a_mag;
                        end else begin
                            opnd_q   <= a_mag;
                            acc_hi_q <= '0;
                            acc_lo_q <= b_mag;
                        end
                    end
                end
                CALC: begin
                    count_q <= count_q + 6'd1;
                    if (op_q[2]) begin
                        acc_hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc_lo_q <= {acc_lo_q[XLEN-2:0], div_ge};
                    end else begin
                        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[XLEN-1:1]};
                    end
                end
                FIX: begin
                    if (!bus.kill_i) begin
                        rd_data_q <= result;
                        rd_out_q  <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o   = (state_q == IDLE);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.valid_o   = (state_q == DONE);
    assign bus.rd_o      = rd_out_q;
    assign bus.rd_data_o = rd_data_q;

endmodule
